// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings, key defaults and FSM state type for the game event controller
//
// Contents:
//   GS_*          game_state encodings driven by state_controller
//   EXIT_*        exit_reason encodings
//   KEY_*_DEF     default keycodes for start and restart
//   gec_state_t   internal FSM states of game_event_controller
//   cnt_width()   width of a counter that must hold 0..max_val, at least 1 bit
package game_pkg;

  localparam logic [1:0] GS_PRE  = 2'b00;
  localparam logic [1:0] GS_IN   = 2'b01;
  localparam logic [1:0] GS_POST = 2'b10;
  localparam logic [1:0] GS_BAD  = 2'b11;

  localparam logic [1:0] EXIT_NONE    = 2'b00;
  localparam logic [1:0] EXIT_LIVES   = 2'b01;
  localparam logic [1:0] EXIT_TIMEOUT = 2'b10;

  localparam logic [7:0] KEY_ENTER_DEF   = 8'h28;
  localparam logic [7:0] KEY_RESTART_DEF = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RUN  = 3'd1,
    S_RUN       = 3'd2,
    S_EXITED    = 3'd3,
    S_POST      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } gec_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - per-round frame counter and seconds countdown
//
// Ports:
//   Clk, Reset   system clock, synchronous active-high reset
//   load         reload the countdown and clear the frame counter (start of round)
//   frame_tick   one-cycle pulse per frame, already in the Clk domain
//   enable       counting allowed (only while the round is live)
//   time_left    remaining seconds, saturates at 0
//   expired      time_left has reached 0
module round_timer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECONDS  = 99
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       frame_tick,
  input  logic       enable,
  output logic [6:0] time_left,
  output logic       expired
);

  localparam int              FW         = cnt_width(FRAMES_PER_SEC - 1);
  localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]      TIME_LOAD  = 7'(ROUND_SECONDS);

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || load) begin
      frame_cnt <= '0;
      time_left <= TIME_LOAD;
    end else if (enable && frame_tick) begin
      if (frame_cnt == FRAME_LAST) begin
        // One full second of frames elapsed; countdown never wraps below 0.
        frame_cnt <= '0;
        if (time_left != 7'd0) begin
          time_left <= time_left - 7'd1;
        end
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign expired = (time_left == 7'd0);

endmodule

// File: rtl/game_event_controller.sv
// rtl/game_event_controller.sv - key decode, lives/timer tracking and enter/exit/start pulses for state_controller
//
// Ports:
//   Clk, Reset    system clock, synchronous active-high reset
//   frame_clk     vsync-rate frame clock, asynchronous to Clk
//   keycode       current keyboard keycode, 0 = no key
//   game_state    from state_controller: 00 pre, 01 in, 10 post
//   hit           one-cycle collision pulse from game logic
//   game_enter    one-cycle pulse: player pressed enter in pre-game
//   game_exit     one-cycle pulse: round over (lives or time exhausted)
//   game_start    one-cycle pulse: player pressed restart in post-game
//   lives         remaining lives (to HUD)
//   time_left     remaining seconds (to HUD)
//   exit_reason   00 none, 01 lives exhausted, 10 timeout
module game_event_controller
  import game_pkg::*;
#(
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         ROUND_SECONDS  = 99,
  parameter int         START_LIVES    = 3,
  parameter int         INVULN_FRAMES  = 30,
  parameter logic [7:0] KEY_ENTER      = KEY_ENTER_DEF,
  parameter logic [7:0] KEY_RESTART    = KEY_RESTART_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [1:0] game_state,
  input  logic       hit,
  output logic       game_enter,
  output logic       game_exit,
  output logic       game_start,
  output logic [1:0] lives,
  output logic [6:0] time_left,
  output logic [1:0] exit_reason
);

  localparam int            IW          = cnt_width(INVULN_FRAMES);
  localparam logic [IW-1:0] INVULN_LOAD = IW'(INVULN_FRAMES);
  localparam logic [1:0]    LIVES_LOAD  = 2'(START_LIVES);

  gec_state_t state, state_next;

  logic          frame_sync1, frame_sync2, frame_sync3, frame_tick;
  logic [7:0]    keycode_d;
  logic          enter_edge, restart_edge;
  logic          freeze, exit_cond, count_en, load, hit_accept, expired;
  logic          enter_next, exit_next, start_next;
  logic [1:0]    reason_next;
  logic [IW-1:0] invuln;

  // frame_clk crosses in through two flops; the third flop gives the edge
  // reference, and frame_tick is registered so it lands 3 cycles after the rise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync1 <= 1'b0;
      frame_sync2 <= 1'b0;
      frame_sync3 <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_sync1 <= frame_clk;
      frame_sync2 <= frame_sync1;
      frame_sync3 <= frame_sync2;
      frame_tick  <= frame_sync2 & ~frame_sync3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_d <= 8'h00;
    end else begin
      keycode_d <= keycode;
    end
  end

  // A held key matches only in the first cycle it appears.
  assign enter_edge   = (keycode == KEY_ENTER)   && (keycode_d != KEY_ENTER);
  assign restart_edge = (keycode == KEY_RESTART) && (keycode_d != KEY_RESTART);

  assign freeze    = (game_state == GS_BAD);
  assign exit_cond = (lives == 2'd0) || expired;
  // Counting stops in the cycle the exit is raised so the latched HUD values
  // are exactly the ones that ended the round.
  assign count_en  = (state == S_RUN) && !freeze && !exit_cond;
  assign load      = (state == S_WAIT_RUN) && (game_state == GS_IN);
  // Acceptance looks at invuln before this cycle's tick decrement, so a hit
  // in the cycle invuln drops to 0 is still ignored.
  assign hit_accept = count_en && hit && (invuln == '0) && (lives != 2'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!freeze) begin
      case (state)
        S_IDLE:      if (game_state == GS_PRE && enter_edge) state_next = S_WAIT_RUN;
        S_WAIT_RUN:  if (game_state == GS_IN)                state_next = S_RUN;
        S_RUN:       if (exit_cond)                          state_next = S_EXITED;
        S_EXITED:    if (game_state == GS_POST)              state_next = S_POST;
        S_POST:      if (restart_edge)                       state_next = S_WAIT_IDLE;
        S_WAIT_IDLE: if (game_state == GS_PRE)               state_next = S_IDLE;
        default:                                             state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    enter_next  = (state == S_IDLE) && (state_next == S_WAIT_RUN);
    exit_next   = (state == S_RUN)  && (state_next == S_EXITED);
    start_next  = (state == S_POST) && (state_next == S_WAIT_IDLE);
    reason_next = (lives == 2'd0) ? EXIT_LIVES : EXIT_TIMEOUT;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_enter <= 1'b0;
      game_exit  <= 1'b0;
      game_start <= 1'b0;
    end else begin
      game_enter <= enter_next;
      game_exit  <= exit_next;
      game_start <= start_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || load) begin
      lives       <= LIVES_LOAD;
      invuln      <= '0;
      exit_reason <= EXIT_NONE;
    end else begin
      if (hit_accept) begin
        lives  <= lives - 2'd1;
        invuln <= INVULN_LOAD;
      end else if (count_en && frame_tick && invuln != '0) begin
        invuln <= invuln - IW'(1);
      end
      if (exit_next) begin
        exit_reason <= reason_next;
      end
    end
  end

  round_timer #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC),
    .ROUND_SECONDS  (ROUND_SECONDS)
  ) u_round_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (load),
    .frame_tick (frame_tick),
    .enable     (count_en),
    .time_left  (time_left),
    .expired    (expired)
  );

endmodule

// File: tb/tb_game_event_controller.sv
// tb/tb_game_event_controller.sv - scoreboard bench for game_event_controller
module tb_game_event_controller;

  localparam int FPS    = 2;
  localparam int ROUND  = 3;
  localparam int LIVES0 = 3;
  localparam int INV    = 2;

  localparam int K_ENTER = 1;
  localparam int K_EXIT  = 2;
  localparam int K_START = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [1:0] game_state;
  logic       hit;
  logic       game_enter, game_exit, game_start;
  logic [1:0] lives;
  logic [6:0] time_left;
  logic [1:0] exit_reason;

  game_event_controller #(
    .FRAMES_PER_SEC (FPS),
    .ROUND_SECONDS  (ROUND),
    .START_LIVES    (LIVES0),
    .INVULN_FRAMES  (INV),
    .KEY_ENTER      (8'h28),
    .KEY_RESTART    (8'h15)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .game_state  (game_state),
    .hit         (hit),
    .game_enter  (game_enter),
    .game_exit   (game_exit),
    .game_start  (game_start),
    .lives       (lives),
    .time_left   (time_left),
    .exit_reason (exit_reason)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int assert_count = 0;
  int fail_count   = 0;

  task automatic check(input string tag, input int observed, input int expected);
    assert_count++;
    if (observed != expected) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  typedef struct {
    int kind;
    int cyc;
    int reason;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_pulse(input int kind, input int at_cyc, input int reason);
    exp_t e;
    e.kind   = kind;
    e.cyc    = at_cyc;
    e.reason = reason;
    sb_q.push_back(e);
  endtask

  // Every pulse the DUT raises must match the head of the scoreboard.
  always @(negedge Clk) begin : monitor
    int   obs;
    exp_t e;
    obs = int'({game_start, game_exit, game_enter});
    if (obs != 0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", obs, 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", obs, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_EXIT) check("exit_reason_at_pulse", int'(exit_reason), e.reason);
      end
    end
  end

  // Reference round model
  int m_lives, m_time, m_frame, m_inv, m_reason;
  bit m_exited;

  task automatic model_load();
    m_lives  = LIVES0;
    m_time   = ROUND;
    m_frame  = 0;
    m_inv    = 0;
    m_reason = 0;
    m_exited = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic after_update();
    check("lives", int'(lives), m_lives);
    check("time_left", int'(time_left), m_time);
    if (!m_exited && (m_lives == 0 || m_time == 0)) begin
      m_exited = 1;
      m_reason = (m_lives == 0) ? 1 : 2;
      expect_pulse(K_EXIT, cyc + 1, m_reason);
    end
  endtask

  task automatic do_frame(input bit with_hit);
    bit acc;
    step(3);
    frame_clk = 1'b1;
    step(3);
    hit = with_hit;
    step(1);
    hit = 1'b0;
    frame_clk = 1'b0;
    acc = with_hit && m_inv == 0 && m_lives > 0;
    if (acc) begin
      m_lives--;
      m_inv = INV;
    end else if (m_inv > 0) begin
      m_inv--;
    end
    if (m_frame == FPS - 1) begin
      m_frame = 0;
      if (m_time > 0) m_time--;
    end else begin
      m_frame++;
    end
    after_update();
  endtask

  task automatic do_hit();
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    if (m_inv == 0 && m_lives > 0) begin
      m_lives--;
      m_inv = INV;
    end
    after_update();
  endtask

  task automatic press(input logic [7:0] k, input int kind, input int hold);
    keycode = k;
    if (kind != 0) expect_pulse(kind, cyc + 1, 0);
    step(hold);
    keycode = 8'h00;
    step(1);
  endtask

  task automatic enter_round();
    game_state = 2'b00;
    step(2);
    press(8'h28, K_ENTER, 3);
    game_state = 2'b01;
    step(2);
    model_load();
    check("load_lives", int'(lives), LIVES0);
    check("load_time", int'(time_left), ROUND);
    check("load_reason", int'(exit_reason), 0);
  endtask

  task automatic finish_round();
    game_state = 2'b10;
    step(2);
    press(8'h28, 0, 3);
    press(8'h15, K_START, 4);
    game_state = 2'b00;
    step(2);
    check("hold_lives", int'(lives), m_lives);
    check("hold_time", int'(time_left), m_time);
    check("hold_reason", int'(exit_reason), m_reason);
  endtask

  initial begin
    Reset      = 1'b1;
    frame_clk  = 1'b0;
    keycode    = 8'h00;
    game_state = 2'b00;
    hit        = 1'b0;
    step(3);
    check("rst_lives", int'(lives), LIVES0);
    check("rst_time", int'(time_left), ROUND);
    check("rst_reason", int'(exit_reason), 0);
    check("rst_pulses", int'({game_start, game_exit, game_enter}), 0);
    Reset = 1'b0;
    step(1);

    // Held enter gives one pulse; re-press while waiting for the round gives none.
    keycode = 8'h28;
    expect_pulse(K_ENTER, cyc + 1, 0);
    step(10);
    keycode = 8'h00;
    step(2);
    press(8'h28, 0, 3);
    step(2);
    game_state = 2'b01;
    step(2);
    model_load();
    check("round1_lives", int'(lives), LIVES0);
    check("round1_time", int'(time_left), ROUND);

    // Timeout round
    repeat (6) do_frame(1'b0);
    step(100);
    check("timeout_reason", int'(exit_reason), 2);
    finish_round();

    // Lives round, including hits inside the invulnerability window
    enter_round();
    do_hit();
    do_frame(1'b0);
    do_frame(1'b1);
    do_frame(1'b1);
    do_frame(1'b0);
    do_hit();
    do_frame(1'b0);
    do_hit();
    step(5);
    check("lives_reason", int'(exit_reason), 1);
    finish_round();

    // Last hit and last second land in the same cycle
    enter_round();
    do_hit();
    do_frame(1'b0);
    do_frame(1'b0);
    do_hit();
    do_frame(1'b0);
    do_frame(1'b0);
    do_frame(1'b0);
    do_frame(1'b1);
    step(5);
    check("simul_reason", int'(exit_reason), 1);
    finish_round();

    // Reset mid-round with lives=1, time_left=1
    enter_round();
    do_hit();
    do_frame(1'b0);
    do_frame(1'b0);
    do_hit();
    do_frame(1'b0);
    do_frame(1'b0);
    Reset = 1'b1;
    hit   = 1'b1;
    step(1);
    check("midrst_lives", int'(lives), LIVES0);
    check("midrst_time", int'(time_left), ROUND);
    check("midrst_reason", int'(exit_reason), 0);
    check("midrst_pulses", int'({game_start, game_exit, game_enter}), 0);
    step(1);
    Reset = 1'b0;
    hit   = 1'b0;
    step(3);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(1);
    check("idle_hit_ignored", int'(lives), LIVES0);
    enter_round();
    do_frame(1'b0);
    do_frame(1'b0);

    step(5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
